// File: rtl/exu_scu_rmw.sv
// Multi-cycle CSR read-modify-write unit: accepts one RW/RS/RC request, reads the CSR
// over a variable-latency bus, applies write suppression / RO checks and returns the old value.
module exu_scu_rmw #(
  parameter int XLEN       = 32,
  parameter int TMO_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic            i_imm,
  input  logic [XLEN-1:0] i_op1,
  input  logic [4:0]      i_zimm,
  input  logic            i_src_zero,
  input  logic            i_rd_x0,
  input  logic [11:0]     i_addr,
  input  logic            i_flush,
  output logic            o_csr_ren,
  output logic [11:0]     o_csr_addr,
  input  logic            i_csr_rvalid,
  input  logic [XLEN-1:0] i_csr_rdata,
  output logic            o_csr_wen,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic            o_rdwen,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_illegal,
  output logic [2:0]      o_dbg_state
);

  // Request handshake: a request transfers when i_valid & o_ready in the same cycle;
  // a response transfers when o_resp_valid & i_resp_ready, and o_ready rises the cycle after.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RESP = 3'd3
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam int         CW    = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic              src_zero_q, src_zero_d;
  logic              rd_x0_q, rd_x0_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              illegal_q, illegal_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              accept;
  logic [XLEN-1:0]   src_in;
  logic              write_needed;
  logic              addr_ro;
  logic [XLEN-1:0]   new_val;

  assign accept       = i_valid & (state_q == S_IDLE) & ~i_flush;
  assign src_in       = i_imm ? {{(XLEN-5){1'b0}}, i_zimm} : i_op1;
  // Set/clear with a zero source must not write, so read-only CSRs stay readable that way.
  assign write_needed = (op_q == OP_RW) | ~src_zero_q;
  assign addr_ro      = (addr_q[11:10] == 2'b11);

  always_comb begin
    new_val = '0;
    case (op_q)
      OP_RW:   new_val = src_q;
      OP_RS:   new_val = i_csr_rdata | src_q;
      default: new_val = i_csr_rdata & ~src_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      rd_x0_q    <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      rd_x0_q    <= rd_x0_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    src_zero_d = src_zero_q;
    rd_x0_d    = rd_x0_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = i_op;
          src_d      = src_in;
          src_zero_d = i_src_zero;
          rd_x0_d    = i_rd_x0;
          addr_d     = i_addr;
          rdata_d    = '0;
          wdata_d    = '0;
          cnt_d      = '0;
          illegal_d  = (i_op == 2'b00);
          state_d    = (i_op == 2'b00) ? S_RESP : S_RD;
        end
      end
      S_RD: begin
        // A read arriving in the last allowed cycle beats the timeout.
        if (i_csr_rvalid) begin
          rdata_d = i_csr_rdata;
          wdata_d = new_val;
          if (write_needed && addr_ro) begin
            illegal_d = 1'b1;
            state_d   = S_RESP;
          end else if (write_needed) begin
            state_d = S_WR;
          end else begin
            state_d = S_RESP;
          end
        end else if (cnt_q == CNT_LAST) begin
          illegal_d = 1'b1;
          rdata_d   = '0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (i_resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (i_flush) begin
      state_d = S_IDLE;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_csr_ren    = accept & (i_op != 2'b00);
  assign o_csr_addr   = (state_q == S_IDLE) ? (accept ? i_addr : 12'h000) : addr_q;
  assign o_csr_wen    = (state_q == S_WR) & ~i_flush;
  assign o_csr_wdata  = (state_q == S_WR) ? wdata_q : '0;
  assign o_resp_valid = (state_q == S_RESP) & ~i_flush;
  assign o_rdata      = (state_q == S_RESP) ? rdata_q : '0;
  assign o_illegal    = (state_q == S_RESP) & illegal_q;
  assign o_rdwen      = (state_q == S_RESP) & ~rd_x0_q & ~illegal_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_exu_scu_rmw.sv
// Directed bench for exu_scu_rmw: a transaction-level model predicts strobes and
// responses with their cycle numbers; one negedge process compares the DUT against it.
module tb_exu_scu_rmw;
  localparam int XLEN = 32;
  localparam int TMO  = 16;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [1:0]      i_op = '0;
  logic            i_imm = 1'b0;
  logic [XLEN-1:0] i_op1 = '0;
  logic [4:0]      i_zimm = '0;
  logic            i_src_zero = 1'b0;
  logic            i_rd_x0 = 1'b0;
  logic [11:0]     i_addr = '0;
  logic            i_flush = 1'b0;
  logic            o_csr_ren;
  logic [11:0]     o_csr_addr;
  logic            i_csr_rvalid = 1'b0;
  logic [XLEN-1:0] i_csr_rdata = '0;
  logic            o_csr_wen;
  logic [XLEN-1:0] o_csr_wdata;
  logic            o_resp_valid;
  logic            i_resp_ready = 1'b0;
  logic            o_rdwen;
  logic [XLEN-1:0] o_rdata;
  logic            o_illegal;
  logic [2:0]      o_dbg_state;

  exu_scu_rmw #(.XLEN(XLEN), .TMO_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_imm(i_imm), .i_op1(i_op1), .i_zimm(i_zimm),
    .i_src_zero(i_src_zero), .i_rd_x0(i_rd_x0), .i_addr(i_addr), .i_flush(i_flush),
    .o_csr_ren(o_csr_ren), .o_csr_addr(o_csr_addr), .i_csr_rvalid(i_csr_rvalid),
    .i_csr_rdata(i_csr_rdata), .o_csr_wen(o_csr_wen), .o_csr_wdata(o_csr_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_rdwen(o_rdwen),
    .o_rdata(o_rdata), .o_illegal(o_illegal), .o_dbg_state(o_dbg_state)
  );

  // Clock / cycle counter
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected events with the cycle they must appear in
  int              exp_ren_cyc_q[$];
  logic [11:0]     exp_ren_addr_q[$];
  int              exp_wen_cyc_q[$];
  logic [XLEN-1:0] exp_q[$];
  int              exp_resp_cyc_q[$];
  logic [XLEN-1:0] exp_rdata_q[$];
  logic [1:0]      exp_rflag_q[$];

  logic [XLEN-1:0] last_wdata = '0;
  logic [XLEN-1:0] last_rdata = '0;
  logic            last_illegal = 1'b0;
  logic            last_rdwen = 1'b0;
  int              last_resp_cyc = 0;
  int              last_hs_cyc = 0;
  int              wen_count = 0;
  int              resp_count = 0;
  bit              resp_open = 1'b0;

  task automatic push_resp(input int c, input logic [XLEN-1:0] rd, input logic ill, input logic rdw);
    exp_resp_cyc_q.push_back(c);
    exp_rdata_q.push_back(rd);
    exp_rflag_q.push_back({ill, rdw});
  endtask

  // Transaction model: what one request must produce, given when the bus answers.
  task automatic model_op(input int a, input logic [1:0] op, input logic imm, input logic [XLEN-1:0] op1,
                          input logic [4:0] zimm, input logic src_zero, input logic rd_x0,
                          input logic [11:0] addr, input logic [XLEN-1:0] old, input int lat);
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] nv;
    logic            wr;
    src = imm ? XLEN'(zimm) : op1;
    if (op == 2'b00) begin
      push_resp(a + 1, '0, 1'b1, 1'b0);
    end else begin
      exp_ren_cyc_q.push_back(a);
      exp_ren_addr_q.push_back(addr);
      if (lat < 1 || lat > TMO) begin
        push_resp(a + TMO + 1, '0, 1'b1, 1'b0);
      end else begin
        wr = (op == 2'b01) || !src_zero;
        if (op == 2'b01)      nv = src;
        else if (op == 2'b10) nv = old | src;
        else                  nv = old & ~src;
        if (wr && addr >= 12'hC00) begin
          push_resp(a + lat + 1, old, 1'b1, 1'b0);
        end else if (wr) begin
          exp_wen_cyc_q.push_back(a + lat + 1);
          exp_q.push_back(nv);
          push_resp(a + lat + 2, old, 1'b0, !rd_x0);
        end else begin
          push_resp(a + lat + 1, old, 1'b0, !rd_x0);
        end
      end
    end
  endtask

  // Compare process
  initial forever begin
    @(negedge i_clk);
    if (i_rstn) begin
      if (o_csr_ren) begin
        if (exp_ren_cyc_q.size() == 0) begin
          chk("ren_unexpected", 32'(o_csr_ren), 32'd0);
        end else begin
          chk("ren_cycle", cyc, exp_ren_cyc_q.pop_front());
          chk("ren_addr", 32'(o_csr_addr), 32'(exp_ren_addr_q.pop_front()));
        end
      end
      if (o_csr_wen) begin
        wen_count++;
        last_wdata = o_csr_wdata;
        if (exp_wen_cyc_q.size() == 0) begin
          chk("wen_unexpected", 32'(o_csr_wen), 32'd0);
        end else begin
          chk("wen_cycle", cyc, exp_wen_cyc_q.pop_front());
          chk("wen_wdata", o_csr_wdata, exp_q.pop_front());
        end
      end
      if (o_resp_valid) begin
        chk("ready_low_in_resp", 32'(o_ready), 32'd0);
        if (exp_resp_cyc_q.size() == 0) begin
          chk("resp_unexpected", 32'(o_resp_valid), 32'd0);
        end else begin
          if (!resp_open) begin
            chk("resp_cycle", cyc, exp_resp_cyc_q[0]);
            last_resp_cyc = cyc;
            resp_open = 1'b1;
          end
          chk("resp_rdata", o_rdata, exp_rdata_q[0]);
          chk("resp_illegal", 32'(o_illegal), 32'(exp_rflag_q[0][1]));
          chk("resp_rdwen", 32'(o_rdwen), 32'(exp_rflag_q[0][0]));
          if (i_resp_ready) begin
            last_rdata   = o_rdata;
            last_illegal = o_illegal;
            last_rdwen   = o_rdwen;
            last_hs_cyc  = cyc;
            resp_count++;
            resp_open = 1'b0;
            void'(exp_resp_cyc_q.pop_front());
            void'(exp_rdata_q.pop_front());
            void'(exp_rflag_q.pop_front());
          end
        end
      end
    end
  end

  // Driver: one full request; lat<=0 means the bus never answers.
  task automatic run_op(input logic [1:0] op, input logic imm, input logic [XLEN-1:0] op1,
                        input logic [4:0] zimm, input logic src_zero, input logic rd_x0,
                        input logic [11:0] addr, input logic [XLEN-1:0] old, input int lat,
                        input int hold, output int acc_cyc);
    int  k;
    int  rv_cnt;
    bit  hs;
    bit  done;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_op = op; i_imm = imm; i_op1 = op1; i_zimm = zimm;
    i_src_zero = src_zero; i_rd_x0 = rd_x0; i_addr = addr; i_resp_ready = 1'b0;
    acc_cyc = cyc;
    model_op(acc_cyc, op, imm, op1, zimm, src_zero, rd_x0, addr, old, lat);
    k = 0; rv_cnt = 0; hs = 1'b0; done = 1'b0;
    while (!done && k < 60) begin
      @(posedge i_clk); #1;
      k++;
      if (hs) begin
        done = 1'b1;
        i_resp_ready = 1'b0;
        i_valid = 1'b0;
        i_csr_rvalid = 1'b0;
        chk("ready_after_resp", 32'(o_ready), 32'd1);
      end else begin
        i_csr_rvalid = (lat > 0 && k == lat);
        i_csr_rdata  = i_csr_rvalid ? old : $urandom;
        if (o_resp_valid) begin
          i_valid = 1'b0;
          rv_cnt++;
          i_resp_ready = (rv_cnt > hold);
          hs = i_resp_ready;
        end else begin
          // Busy: scribble over the request inputs, they must be ignored.
          i_valid = 1'b1; i_op = 2'($urandom_range(0, 3)); i_addr = 12'($urandom);
          i_op1 = $urandom; i_zimm = 5'($urandom); i_src_zero = 1'($urandom);
          i_rd_x0 = 1'($urandom); i_imm = 1'($urandom);
          i_resp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL op_budget actual=no_handshake required=handshake within 60 cycles");
      i_valid = 1'b0; i_resp_ready = 1'b0; i_csr_rvalid = 1'b0;
    end
  endtask

  task automatic chk_outputs_idle(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_ren"}, 32'(o_csr_ren), 32'd0);
    chk({tag, "_addr"}, 32'(o_csr_addr), 32'd0);
    chk({tag, "_wen"}, 32'(o_csr_wen), 32'd0);
    chk({tag, "_wdata"}, o_csr_wdata, 32'd0);
    chk({tag, "_rvalid"}, 32'(o_resp_valid), 32'd0);
    chk({tag, "_rdwen"}, 32'(o_rdwen), 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_illegal"}, 32'(o_illegal), 32'd0);
    chk({tag, "_state"}, 32'(o_dbg_state), 32'd0);
  endtask

  int a;
  int w0;
  int r0;

  initial begin
    // Reset block
    #2;
    chk_outputs_idle("rst");
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;

    // 1: RS register source
    run_op(2'b10, 1'b0, 32'h0000_000F, 5'd0, 1'b0, 1'b0, 12'h300, 32'h0000_00F0, 2, 0, a);
    chk("t1_wdata", last_wdata, 32'h0000_00FF);
    chk("t1_rdata", last_rdata, 32'h0000_00F0);
    chk("t1_rdwen", 32'(last_rdwen), 32'd1);
    chk("t1_latency", last_resp_cyc - a, 32'd4);

    // 2: RC immediate with zimm=0 suppresses the write
    w0 = wen_count;
    run_op(2'b11, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 12'h305, 32'h1234_5678, 1, 0, a);
    chk("t2_no_wen", wen_count - w0, 32'd0);
    chk("t2_rdata", last_rdata, 32'h1234_5678);
    chk("t2_illegal", 32'(last_illegal), 32'd0);

    // 3: RW to a read-only CSR
    w0 = wen_count;
    run_op(2'b01, 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 12'hC00, 32'h0000_0042, 1, 0, a);
    chk("t3_no_wen", wen_count - w0, 32'd0);
    chk("t3_illegal", 32'(last_illegal), 32'd1);
    chk("t3_rdwen", 32'(last_rdwen), 32'd0);

    // 4: bus never answers
    run_op(2'b01, 1'b0, 32'h1, 5'd0, 1'b0, 1'b0, 12'h340, 32'h0, -1, 0, a);
    chk("t4_latency", last_resp_cyc - a, 32'd17);
    chk("t4_rdata", last_rdata, 32'd0);
    chk("t4_illegal", 32'(last_illegal), 32'd1);

    // rvalid in the final allowed cycle wins; one cycle later times out
    run_op(2'b10, 1'b1, 32'h0, 5'h11, 1'b0, 1'b0, 12'h344, 32'h0000_0100, 16, 0, a);
    chk("tmo_edge_wdata", last_wdata, 32'h0000_0111);
    run_op(2'b10, 1'b1, 32'h0, 5'h11, 1'b0, 1'b0, 12'h344, 32'h0000_0100, 17, 0, a);
    chk("tmo_over_illegal", 32'(last_illegal), 32'd1);

    // Reserved op, RS-zero read of a read-only CSR, RW with rd=x0
    run_op(2'b00, 1'b0, 32'h5, 5'd0, 1'b0, 1'b0, 12'h300, 32'h0, 1, 0, a);
    chk("op00_latency", last_resp_cyc - a, 32'd1);
    run_op(2'b10, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 12'hF14, 32'h0000_0007, 3, 0, a);
    chk("ro_read_rdwen", 32'(last_rdwen), 32'd1);
    run_op(2'b01, 1'b1, 32'h0, 5'h1F, 1'b0, 1'b1, 12'h341, 32'hAAAA_0000, 1, 0, a);
    chk("rw_zimm_wdata", last_wdata, 32'h0000_001F);
    chk("rw_x0_rdwen", 32'(last_rdwen), 32'd0);

    // 5: flush while reading, then a late rvalid
    w0 = wen_count; r0 = resp_count;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_op = 2'b01; i_imm = 1'b0; i_op1 = 32'h77; i_src_zero = 1'b0;
    i_rd_x0 = 1'b0; i_addr = 12'h342; a = cyc;
    exp_ren_cyc_q.push_back(a);
    exp_ren_addr_q.push_back(12'h342);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("t5_idle_after_flush", 32'(o_ready), 32'd1);
    i_csr_rvalid = 1'b1; i_csr_rdata = 32'hBAD0_BAD0;
    @(posedge i_clk); #1;
    i_csr_rvalid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("t5_no_wen", wen_count - w0, 32'd0);
    chk("t5_no_resp", resp_count - r0, 32'd0);
    run_op(2'b01, 1'b0, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 12'h342, 32'h0000_9999, 3, 0, a);
    chk("t5_next_wdata", last_wdata, 32'h0000_1234);
    chk("t5_next_rdata", last_rdata, 32'h0000_9999);

    // 6: response held for 5 cycles
    run_op(2'b11, 1'b0, 32'h0000_FF00, 5'd0, 1'b0, 1'b0, 12'h300, 32'hFFFF_FFFF, 1, 5, a);
    chk("t6_hold_cycles", last_hs_cyc - last_resp_cyc, 32'd5);
    chk("t6_wdata", last_wdata, 32'hFFFF_00FF);
    chk("t6_rdata", last_rdata, 32'hFFFF_FFFF);

    // Async reset in the middle of a read
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_op = 2'b01; i_imm = 1'b0; i_op1 = 32'hA5; i_src_zero = 1'b0;
    i_rd_x0 = 1'b0; i_addr = 12'h301; a = cyc;
    exp_ren_cyc_q.push_back(a);
    exp_ren_addr_q.push_back(12'h301);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    #2 i_rstn = 1'b0;
    #1 chk_outputs_idle("mid_rst");
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    run_op(2'b10, 1'b0, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 12'h300, 32'h0000_0002, 2, 1, a);
    chk("post_rst_wdata", last_wdata, 32'h0000_0003);

    repeat (3) @(posedge i_clk);
    #1;
    chk("ren_q_empty", exp_ren_cyc_q.size(), 32'd0);
    chk("wen_q_empty", exp_wen_cyc_q.size(), 32'd0);
    chk("resp_q_empty", exp_resp_cyc_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
